// File: rtl/cla_pkg.sv
// ----------------------------------------------------------------------------
// cla_pkg -- shared types and constants for the sequential borrow-lookahead
// subtractor (cla_sub_seq).
//   state_t  : FSM encoding (IDLE / RUN / DONE)
//   NIB_W    : bits handled per RUN cycle
//   nib_cnt  : number of nibbles (RUN cycles) for a given operand width
// ----------------------------------------------------------------------------
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_cnt(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/blu_nibble.sv
// ----------------------------------------------------------------------------
// blu_nibble -- combinational 4-bit borrow-lookahead subtract unit.
//   a[3:0]  : minuend nibble
//   b[3:0]  : subtrahend nibble
//   bi      : borrow into bit 0
//   d[3:0]  : a - b - bi (mod 16)
//   bo      : borrow out of bit 3
// Per bit: generate g = ~a & b (borrow created), propagate p = ~(a ^ b)
// (incoming borrow passes through). Every internal borrow is a flat
// sum-of-products of g/p/bi, so no borrow waits on its neighbour.
// ----------------------------------------------------------------------------
module blu_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bi,
    output logic [3:0] d,
    output logic       bo
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;   // borrow into each bit

    assign g = ~a & b;
    assign p = ~(a ^ b);

    assign c[0] = bi;
    assign c[1] = g[0]
                | (p[0] & bi);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & bi);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bi);
    assign bo   = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bi);

    assign d = a ^ b ^ c;

endmodule

// File: rtl/cla_sub_seq.sv
// ----------------------------------------------------------------------------
// cla_sub_seq -- sequential subtractor: diff = A - B - bIn, one nibble per
// cycle through a borrow-lookahead nibble unit, LSB nibble first.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operands present          in_ready : accepting (IDLE only)
//   A, B       : WIDTH-bit unsigned minuend / subtrahend
//   bIn        : borrow-in
//   out_valid  : result present (DONE)     out_ready: consumer takes result
//   diff       : A - B - bIn mod 2^WIDTH
//   bOut       : borrow out of MSB (A < B + bIn)
//   ovf        : signed overflow, only when CLA_SUB_OVF_EN is defined
//
// Latency is WIDTH/4 cycles from the accepting edge to out_valid. diff is
// rewritten nibble by nibble in RUN and otherwise keeps its last value.
// ----------------------------------------------------------------------------
module cla_sub_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bOut
`ifdef CLA_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBS  = nib_cnt(WIDTH);
    localparam int IDX_W = $clog2(NIBS);

    if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("cla_sub_seq: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               brw_q;    // borrow carried between nibbles
    logic [IDX_W-1:0]   idx;

    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [NIB_W-1:0]   nib_d;
    logic               nib_bo;
    logic               last;

    assign nib_a = a_q[idx*NIB_W +: NIB_W];
    assign nib_b = b_q[idx*NIB_W +: NIB_W];
    assign last  = (idx == IDX_W'(NIBS - 1));

    // in_ready is gated by rst_n so it drops in the same cycle reset asserts.
    assign in_ready = (state == IDLE) && rst_n;

    blu_nibble u_blu (
        .a  (nib_a),
        .b  (nib_b),
        .bi (brw_q),
        .d  (nib_d),
        .bo (nib_bo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            diff      <= '0;
            bOut      <= 1'b0;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            brw_q     <= 1'b0;
`ifdef CLA_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q   <= A;
                        b_q   <= B;
                        brw_q <= bIn;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    diff[idx*NIB_W +: NIB_W] <= nib_d;
                    brw_q                    <= nib_bo;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        bOut      <= nib_bo;
`ifdef CLA_SUB_OVF_EN
                        // operand signs differ and result sign left A's sign
                        ovf       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                                     (nib_d[NIB_W-1] ^ a_q[WIDTH-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sub_seq.sv
// ----------------------------------------------------------------------------
// tb_cla_sub_seq -- scoreboard bench for cla_sub_seq (WIDTH = 16).
// Expected results are pushed when operands are accepted and popped at the
// output handshake. Inputs change #1 after a rising edge; outputs are read
// at that same point, clear of the active edge.
// ----------------------------------------------------------------------------
module tb_cla_sub_seq;

    localparam int W    = 16;
    localparam int NIBS = W / 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         bIn;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bOut;
`ifdef CLA_SUB_OVF_EN
    logic         ovf;
`endif

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cla_sub_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bIn       (bIn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bOut      (bOut)
`ifdef CLA_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t       e;
        logic [W:0] r;
        r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        return e;
    endfunction

    // Full transaction: wait for in_ready, accept, check latency, hold the
    // result for 'hold' cycles under back-pressure, then drain and compare.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input int hold);
        int           n;
        int           lat;
        logic [W-1:0] d_hold;
        exp_t         e;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        A = a; B = b; bIn = bi; in_valid = 1'b1;
        out_ready = (hold == 0);   // asserted early: must be ignored in RUN
        sb.push_back(model(a, b, bi));
        step();
        in_valid = 1'b0;
        A = ~a; B = ~b; bIn = ~bi; // captured operands must not follow inputs
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        chk("latency", 64'(lat), 64'(NIBS));
        d_hold = diff;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;       // must be ignored in DONE
            A = 16'hDEAD; B = 16'hBEEF;
            step();
            chk("hold_diff", 64'(diff), 64'(d_hold));
            chk("hold_inrdy", {63'd0, in_ready}, 64'd0);
            chk("hold_ovld", {63'd0, out_valid}, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = sb.pop_front();
        chk("diff", 64'(diff), 64'(e.d));
        chk("bOut", {63'd0, bOut}, {63'd0, e.bo});
`ifdef CLA_SUB_OVF_EN
        chk("ovf", {63'd0, ovf}, {63'd0, e.ov});
`endif
        step();
        out_ready = 1'b0;
        chk("idle_inrdy", {63'd0, in_ready}, 64'd1);
        chk("idle_ovld", {63'd0, out_valid}, 64'd0);
        chk("idle_diff", 64'(diff), 64'(e.d));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; bIn = 1'b0;
        step();
        step();
        chk("rst_ovld", {63'd0, out_valid}, 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_bout", {63'd0, bOut}, 64'd0);
        chk("rst_inrdy", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;
        step();

        run_op(16'h1234, 16'h0234, 1'b0, 0);
        run_op(16'h0000, 16'h0001, 1'b0, 1);
        run_op(16'h8000, 16'h0000, 1'b1, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 2);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
        run_op(16'h4321, 16'h1234, 1'b1, 5);  // back-pressure case

        for (int i = 0; i < 12; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        // Reset in the middle of RUN: operation is dropped, no result appears.
        A = 16'h1234; B = 16'h0111; bIn = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();                    // nibble 0
        step();                    // nibble 1
        rst_n = 1'b0;
        step();
        chk("mid_rst_ovld", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_diff", 64'(diff), 64'd0);
        chk("mid_rst_inrdy", {63'd0, in_ready}, 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NIBS + 2; i++) begin
            step();
            chk("mid_rst_no_out", {63'd0, out_valid}, 64'd0);
        end
        run_op(16'h0005, 16'h0003, 1'b0, 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
